// File: rtl/hashmap_cache.sv
// hashmap_cache: direct-mapped key/value table with XOR-folded slot index, combinational lookup and collision flag.
module hashmap_cache #(
    parameter int KEY_WIDTH   = 2,
    parameter int VALUE_WIDTH = 2,
    parameter int CACHE_SIZE  = 4,
    parameter bit OVERWRITE   = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [KEY_WIDTH-1:0]   write_key,
    input  logic [VALUE_WIDTH-1:0] write_value,
    input  logic                   write_request,
    output logic                   collision,
    input  logic [KEY_WIDTH-1:0]   read_key,
    output logic [VALUE_WIDTH-1:0] read_value,
    output logic                   read_response,
    input  logic                   clear_cache
);
    localparam int IW  = $clog2(CACHE_SIZE);
    localparam int NCH = (KEY_WIDTH + IW - 1) / IW;
    localparam int PW  = NCH * IW;

    logic [CACHE_SIZE-1:0]  valid_q, valid_d;
    logic [KEY_WIDTH-1:0]   key_q [CACHE_SIZE];
    logic [VALUE_WIDTH-1:0] val_q [CACHE_SIZE];
    logic [IW-1:0]          rd_idx, wr_idx;
    logic                   wr_en;

    // Zero-padding the key to whole chunks also covers KEY_WIDTH <= IW (single chunk).
    function automatic logic [IW-1:0] hash(input logic [KEY_WIDTH-1:0] k);
        logic [PW-1:0] p;
        logic [IW-1:0] h;
        p = PW'(k);
        h = '0;
        for (int i = 0; i < NCH; i++) h ^= p[i*IW +: IW];
        return h;
    endfunction

    always_comb begin
        rd_idx        = hash(read_key);
        wr_idx        = hash(write_key);
        read_response = valid_q[rd_idx] && (key_q[rd_idx] == read_key);
        read_value    = read_response ? val_q[rd_idx] : '0;
        collision     = write_request && valid_q[wr_idx] && (key_q[wr_idx] != write_key);
        wr_en         = write_request && !clear_cache && (!collision || OVERWRITE);
        valid_d       = clear_cache ? '0 : wr_en ? (valid_q | (CACHE_SIZE'(1) << wr_idx)) : valid_q;
    end

    always_ff @(posedge clk) valid_q <= rst ? '0 : valid_d;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            key_q[wr_idx] <= write_key;
            val_q[wr_idx] <= write_value;
        end
    end
endmodule

// File: tb/tb_hashmap_cache.sv
// tb_hashmap_cache: directed checks on two instances sharing stimulus, one with OVERWRITE=1 and one with OVERWRITE=0.
module tb_hashmap_cache;
    logic       clk = 1'b0;
    logic       rst, write_request, clear_cache;
    logic [3:0] write_key, read_key;
    logic [2:0] write_value;
    logic       col1, rr1, col0, rr0;
    logic [2:0] rv1, rv0;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    hashmap_cache #(.KEY_WIDTH(4), .VALUE_WIDTH(3), .CACHE_SIZE(4), .OVERWRITE(1'b1)) dut1 (
        .clk(clk), .rst(rst), .write_key(write_key), .write_value(write_value),
        .write_request(write_request), .collision(col1), .read_key(read_key),
        .read_value(rv1), .read_response(rr1), .clear_cache(clear_cache)
    );
    hashmap_cache #(.KEY_WIDTH(4), .VALUE_WIDTH(3), .CACHE_SIZE(4), .OVERWRITE(1'b0)) dut0 (
        .clk(clk), .rst(rst), .write_key(write_key), .write_value(write_value),
        .write_request(write_request), .collision(col0), .read_key(read_key),
        .read_value(rv0), .read_response(rr0), .clear_cache(clear_cache)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Looks up key and checks response/value of both instances.
    task automatic rd(input string tag, input logic [3:0] k, input logic e_r1, input logic [2:0] e_v1,
                      input logic e_r0, input logic [2:0] e_v0);
        read_key = k;
        #1;
        check({tag, " resp ow1"}, 32'(rr1), 32'(e_r1));
        check({tag, " val ow1"},  32'(rv1), 32'(e_v1));
        check({tag, " resp ow0"}, 32'(rr0), 32'(e_r0));
        check({tag, " val ow0"},  32'(rv0), 32'(e_v0));
    endtask

    task automatic wr(input logic [3:0] k, input logic [2:0] v);
        write_request = 1'b1;
        write_key     = k;
        write_value   = v;
    endtask

    initial begin
        rst = 1'b1; write_request = 1'b0; clear_cache = 1'b0;
        write_key = '0; write_value = '0; read_key = '0;
        step();
        step();
        rst = 1'b0;
        wr(4'h5, 3'd3);
        rd("reset empty", 4'h5, 1'b0, 3'd0, 1'b0, 3'd0);
        check("reset collision ow1", 32'(col1), 32'd0);
        check("reset collision ow0", 32'(col0), 32'd0);
        step();
        write_request = 1'b0;
        rd("write visible next cycle", 4'h5, 1'b1, 3'd3, 1'b1, 3'd3);
        wr(4'h1, 3'd2);
        step();
        write_request = 1'b0;
        rd("shared slot miss", 4'h4, 1'b0, 3'd0, 1'b0, 3'd0);
        rd("hit 0x1", 4'h1, 1'b1, 3'd2, 1'b1, 3'd2);
        wr(4'h4, 3'd6);
        #1;
        check("collision ow1", 32'(col1), 32'd1);
        check("collision ow0", 32'(col0), 32'd1);
        step();
        write_request = 1'b0;
        rd("after collision 0x4", 4'h4, 1'b1, 3'd6, 1'b0, 3'd0);
        rd("after collision 0x1", 4'h1, 1'b0, 3'd0, 1'b1, 3'd2);
        wr(4'h7, 3'd1);
        step();
        wr(4'h7, 3'd5);
        rd("same cycle read old value", 4'h7, 1'b1, 3'd1, 1'b1, 3'd1);
        check("same key no collision", 32'(col1), 32'd0);
        step();
        write_request = 1'b0;
        rd("same key update", 4'h7, 1'b1, 3'd5, 1'b1, 3'd5);
        clear_cache = 1'b1;
        step();
        clear_cache = 1'b0;
        rd("clear empties", 4'h7, 1'b0, 3'd0, 1'b0, 3'd0);
        wr(4'h2, 3'd4);
        step();
        wr(4'h3, 3'd5);
        step();
        write_request = 1'b0;
        rd("hit 0x2", 4'h2, 1'b1, 3'd4, 1'b1, 3'd4);
        rd("hit 0x3", 4'h3, 1'b1, 3'd5, 1'b1, 3'd5);
        wr(4'h9, 3'd7);
        clear_cache = 1'b1;
        step();
        write_request = 1'b0;
        clear_cache   = 1'b0;
        rd("clear wins 0x2", 4'h2, 1'b0, 3'd0, 1'b0, 3'd0);
        rd("clear wins 0x3", 4'h3, 1'b0, 3'd0, 1'b0, 3'd0);
        rd("clear wins 0x9", 4'h9, 1'b0, 3'd0, 1'b0, 3'd0);
        wr(4'h5, 3'd3);
        step();
        write_request = 1'b0;
        rd("hit before reset", 4'h5, 1'b1, 3'd3, 1'b1, 3'd3);
        rst = 1'b1;
        wr(4'h6, 3'd2);
        step();
        rst = 1'b0;
        write_request = 1'b0;
        rd("reset discards 0x5", 4'h5, 1'b0, 3'd0, 1'b0, 3'd0);
        rd("reset beats write 0x6", 4'h6, 1'b0, 3'd0, 1'b0, 3'd0);
        wr(4'h1, 3'd1);
        #1;
        check("no collision after reset", 32'(col1), 32'd0);
        step();
        write_request = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
